// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: credit-limited request issue, in-order response buffer, redirect flush.
// Optional fetch/bubble performance counters are compiled in when IF_PERF_CNT_EN is defined.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic [31:0] PCPlus4,
  output logic        if_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = AddrW + 1;
  localparam logic [CntW:0] DepthOcc = (CntW + 1)'(FIFO_DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0]  inflight_q, inflight_d;
  logic [CntW-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [AddrW-1:0] rb_wptr_q, rb_wptr_d;
  logic [AddrW-1:0] rb_rptr_q, rb_rptr_d;
  logic [AddrW-1:0] aq_wptr_q, aq_wptr_d;
  logic [AddrW-1:0] aq_rptr_q, aq_rptr_d;

  logic [31:0] rb_pc_q   [FIFO_DEPTH];
  logic [31:0] rb_data_q [FIFO_DEPTH];
  logic [31:0] aq_pc_q   [FIFO_DEPTH];

  logic [CntW:0] occupancy;
  logic          req_fire;
  logic          rsp_take;
  logic          rsp_keep;
  logic          pop;

  // Credit covers requests in flight plus buffered entries, so the buffer can never overflow.
  always_comb begin
    occupancy      = {1'b0, inflight_q} + {1'b0, count_q};
    imem_req_valid = rst && !redirect && (occupancy < DepthOcc);
    imem_addr      = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_take       = imem_rsp_valid && (inflight_q != '0);
    rsp_keep       = rsp_take && (drop_cnt_q == '0) && !redirect;
    if_valid       = (count_q != '0);
    pop            = if_valid && !stall && !redirect;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q + CntW'(req_fire) - CntW'(rsp_take);
    drop_cnt_d = drop_cnt_q;
    count_d    = count_q;
    rb_wptr_d  = rb_wptr_q;
    rb_rptr_d  = rb_rptr_q;
    aq_wptr_d  = aq_wptr_q;
    aq_rptr_d  = aq_rptr_q;

    if (redirect) begin
      // Everything still outstanding belongs to the wrong path, including a response landing now.
      fetch_pc_d = redirect_target;
      drop_cnt_d = inflight_q - CntW'(rsp_take);
      count_d    = '0;
      rb_wptr_d  = '0;
      rb_rptr_d  = '0;
      aq_wptr_d  = '0;
      aq_rptr_d  = '0;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        aq_wptr_d  = aq_wptr_q + AddrW'(1);
      end
      if (rsp_take && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CntW'(1);
      end
      if (rsp_keep) begin
        rb_wptr_d = rb_wptr_q + AddrW'(1);
        aq_rptr_d = aq_rptr_q + AddrW'(1);
      end
      if (pop) begin
        rb_rptr_d = rb_rptr_q + AddrW'(1);
      end
      count_d = count_q + CntW'(rsp_keep) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      count_q    <= '0;
      rb_wptr_q  <= '0;
      rb_rptr_q  <= '0;
      aq_wptr_q  <= '0;
      aq_rptr_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      count_q    <= count_d;
      rb_wptr_q  <= rb_wptr_d;
      rb_rptr_q  <= rb_rptr_d;
      aq_wptr_q  <= aq_wptr_d;
      aq_rptr_q  <= aq_rptr_d;
    end
  end

  // Storage arrays need no reset: occupancy counters gate every read.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      aq_pc_q[aq_wptr_q] <= fetch_pc_q;
    end
    if (rsp_keep) begin
      rb_pc_q[rb_wptr_q]   <= aq_pc_q[aq_rptr_q];
      rb_data_q[rb_wptr_q] <= imem_rsp_data;
    end
  end

  always_comb begin
    pc          = '0;
    instruction = NOP_INSTR;
    PCPlus4     = '0;
    if (if_valid) begin
      pc          = rb_pc_q[rb_rptr_q];
      instruction = rb_data_q[rb_rptr_q];
      PCPlus4     = rb_pc_q[rb_rptr_q] + 32'd4;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + 32'(pop);
    bubble_cnt_d = bubble_cnt_q + 32'(!if_valid && !stall);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomised bench for if_fetch_unit: in-order memory model with variable latency and a
// scoreboard of expected program-order PCs that a separate monitor checks every cycle.
module tb_if_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam logic [31:0] Nop     = 32'h0000_0013;
  localparam int          Depth   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic [31:0] PCPlus4;
  logic        if_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
  logic [31:0] m_fcnt;
  logic [31:0] m_bcnt;
`endif

  if_fetch_unit #(
    .RESET_PC  (ResetPc),
    .FIFO_DEPTH(Depth),
    .NOP_INSTR (Nop)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .pc             (pc),
    .instruction    (instruction),
    .PCPlus4        (PCPlus4),
    .if_valid       (if_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .bubble_cnt     (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Stimulus knobs and environment state.
  int          stall_pct = 0;
  int          redir_pct = 0;
  int          ready_pct = 100;
  int          lat_max   = 1;
  int          phase     = 0;
  int          cyc       = 0;
  int          last_due  = 0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] exp_q[$];
  logic [31:0] stream_pc = ResetPc;

  // Monitor model state.
  int          m_out = 0;
  int          m_drop = 0;
  int          m_buf = 0;
  logic [31:0] m_fetch = ResetPc;
  int          since_rel = -1;
  bit          first_seen = 1'b0;
  int          pops_a = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(stream_pc);
      stream_pc += 32'd4;
    end
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      rst            = 1'b0;
      stall          = 1'b0;
      redirect       = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      pend_addr.delete();
      pend_due.delete();
      last_due = cyc;
      exp_q.delete();
      stream_pc = ResetPc;
      refill();
    end
  endtask

  // One cycle of stimulus; negative arguments mean "randomise from the knobs".
  task automatic step(input int st, input int rdy, input int rd, input logic [31:0] tgt);
    int due;
    @(negedge clk);
    cyc++;
    rst            = 1'b1;
    stall          = (st < 0) ? ($urandom_range(99) < stall_pct) : st[0];
    imem_req_ready = (rdy < 0) ? ($urandom_range(99) < ready_pct) : rdy[0];
    redirect       = (rd < 0) ? ($urandom_range(99) < redir_pct) : rd[0];
    if (rd < 0) redirect_target = ($urandom_range(7) == 0) ? 32'hFFFF_FFF4
                                                           : ($urandom_range(255) << 4);
    else        redirect_target = tgt;
    if (redirect) begin
      exp_q.delete();
      stream_pc = redirect_target;
    end
    refill();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    #1;
    if (imem_req_valid && imem_req_ready) begin
      due = cyc + int'($urandom_range(lat_max, 1));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_addr.push_back(imem_addr);
      pend_due.push_back(due);
    end
  endtask

  initial begin : monitor
    logic [31:0] p;
    bit rsp, acc;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_instr", instruction, Nop);
        check("rst_pc", pc, 32'd0);
        check("rst_pcplus4", PCPlus4, 32'd0);
        m_out = 0; m_drop = 0; m_buf = 0; m_fetch = ResetPc;
        since_rel = -1; first_seen = 1'b0;
`ifdef IF_PERF_CNT_EN
        check("rst_fetch_cnt", fetch_cnt, 32'd0);
        check("rst_bubble_cnt", bubble_cnt, 32'd0);
        m_fcnt = '0; m_bcnt = '0;
`endif
      end else begin
        since_rel++;
        check("req_valid", 32'(imem_req_valid), 32'(!redirect && (m_out + m_buf < Depth)));
        if (imem_req_valid) check("req_addr", imem_addr, m_fetch);
        check("if_valid", 32'(if_valid), 32'(m_buf > 0));
`ifdef IF_PERF_CNT_EN
        check("fetch_cnt", fetch_cnt, m_fcnt);
        check("bubble_cnt", bubble_cnt, m_bcnt);
        if (m_buf == 0 && !stall) m_bcnt += 32'd1;
`endif
        if (!if_valid) begin
          check("empty_instr", instruction, Nop);
          check("empty_pc", pc, 32'd0);
          check("empty_pcplus4", PCPlus4, 32'd0);
        end else if (!redirect) begin
          if (exp_q.size() == 0) begin
            check("exp_queue_nonempty", 32'd0, 32'd1);
          end else begin
            p = exp_q[0];
            check("head_pc", pc, p);
            check("head_instr", instruction, memf(p));
            check("head_pcplus4", PCPlus4, p + 32'd4);
            if (!stall) begin
              void'(exp_q.pop_front());
              if (phase == 0) pops_a++;
`ifdef IF_PERF_CNT_EN
              m_fcnt += 32'd1;
`endif
            end
          end
        end
        if (if_valid && !stall && !redirect && m_buf > 0) m_buf--;
        if (phase == 0 && if_valid && !first_seen) begin
          first_seen = 1'b1;
          check("first_valid_cycle", 32'(since_rel), 32'd2);
        end
        rsp = imem_rsp_valid && (m_out > 0);
        acc = imem_req_valid && imem_req_ready;
        if (redirect) begin
          m_drop  = m_out - int'(rsp);
          m_out   = m_out - int'(rsp);
          m_buf   = 0;
          m_fetch = redirect_target;
        end else begin
          if (rsp) begin
            m_out--;
            if (m_drop > 0) m_drop--;
            else            m_buf++;
          end
          if (acc) begin
            m_out++;
            m_fetch += 32'd4;
          end
        end
      end
    end
  end

  initial begin : stimulus
    do_reset(3);
    // Clean streaming: 1-cycle memory, always ready, no stall.
    repeat (40) step(0, 1, 0, 32'd0);
    #3;
    check("throughput_pops", 32'(pops_a), 32'd38);
    phase = 1;
    // Stall while streaming, then release.
    repeat (5) step(1, 1, 0, 32'd0);
    repeat (6) step(0, 1, 0, 32'd0);
    // Memory not ready for three cycles, drain to empty.
    repeat (3) step(0, 0, 0, 32'd0);
    repeat (6) step(0, 0, 0, 32'd0);
    repeat (4) step(0, 1, 0, 32'd0);
    // Redirect with requests in flight.
    lat_max = 3;
    repeat (4) step(0, 1, 0, 32'd0);
    step(0, 1, 1, 32'h0000_0100);
    repeat (10) step(0, 1, 0, 32'd0);
    // Redirect together with stall while a response is returning.
    lat_max = 1;
    repeat (5) step(0, 1, 0, 32'd0);
    step(1, 1, 1, 32'h0000_0200);
    repeat (8) step(0, 1, 0, 32'd0);
    // Address wrap through 0xFFFFFFFC.
    step(0, 1, 1, 32'hFFFF_FFF8);
    repeat (10) step(0, 1, 0, 32'd0);
    // Random traffic.
    stall_pct = 30; redir_pct = 5; ready_pct = 70; lat_max = 4;
    repeat (1500) step(-1, -1, -1, 32'd0);
    // Fill the buffer under stall, then reset mid-operation.
    stall_pct = 100; redir_pct = 0; ready_pct = 100; lat_max = 1;
    repeat (6) step(-1, -1, -1, 32'd0);
    do_reset(2);
    stall_pct = 25; redir_pct = 4; ready_pct = 80; lat_max = 3;
    repeat (600) step(-1, -1, -1, 32'd0);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage. Owns the fetch PC and issues requests to instruction memory over a valid/ready request channel.
- Collects in-order responses into a small buffer.
- Presents pc / instruction / PCPlus4 plus valid to the IF/ID pipeline register.
- Honours the hazard-unit stall and the EX-stage branch/jump redirect, discarding wrong-path fetches.

Parameters:
- RESET_PC, 32'h00000000: fetch address after reset.
- FIFO_DEPTH, 4: response buffer entries (power of 2, ≥2); also the cap on in-flight requests plus buffered entries.
- NOP_INSTR, 32'h00000013: instruction presented when no valid entry (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- stall  in  1  IF/ID holds; head entry must not be consumed.
- redirect  in  1  branch/jump taken; flush and refetch.
- redirect_target  in  32  new fetch address.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  32  request address (fetch PC).
- imem_rsp_valid  in  1  response data valid; in order, ≥1 cycle after accept.
- imem_rsp_data  in  32  instruction word.
- pc  out  32  PC of head entry.
- instruction  out  32  head instruction, or NOP_INSTR when empty.
- PCPlus4  out  32  pc + 4 of head entry.
- if_valid  out  1  head entry valid.

Behaviour:
- Reset (rst=0, async):
  - fetch_pc=RESET_PC; FIFO empty; inflight=0; drop_cnt=0.
  - imem_req_valid=0.
  - Outputs: pc=0, PCPlus4=0, instruction=NOP_INSTR, if_valid=0.
  - Reset mid-operation discards all entries and in-flight state; responses to pre-reset requests are not expected (memory is reset together).
- Request issue:
  - imem_req_valid = !redirect && (inflight + count < FIFO_DEPTH); imem_addr = fetch_pc.
  - On accept (valid&&ready): fetch_pc += 4 (32-bit wrap, 0xFFFFFFFC → 0); inflight += 1.
  - fetch_pc holds while !ready. Stall does not block issue; only credit does.
- Response:
  - On imem_rsp_valid: inflight -= 1.
  - If drop_cnt>0: drop_cnt -= 1, data discarded.
  - Otherwise push {pc_of_request, data}. Request PCs are tracked in a FIFO_DEPTH-entry address queue written on accept.
  - Credit rule guarantees no overflow. A response with inflight==0 is a protocol error and is ignored.
- Output / consume:
  - pc / instruction / PCPlus4 / if_valid are combinational from the FIFO head.
  - Pop when if_valid && !stall && !redirect.
  - Empty: if_valid=0, instruction=NOP_INSTR, pc=PCPlus4=0.
  - Push and pop in the same cycle are allowed; count is unchanged.
- Redirect (single cycle, highest priority):
  - fetch_pc <= redirect_target; FIFO and address queue cleared.
  - drop_cnt <= inflight − (rsp_valid this cycle ? 1 : 0) + drop_cnt adjustment, so every pre-redirect request is dropped, including one returning this cycle.
  - No request is issued in the redirect cycle.
  - First correct-path request is issued the next cycle; earliest if_valid of the target is 2 cycles after the redirect with a 1-cycle memory.
- Redirect with stall: redirect wins; the flush occurs.
- Throughput: 1 instruction/cycle sustained with 1-cycle memory and ready=1.

Optional Feature:
- IF_PERF_CNT_EN defined: adds outputs fetch_cnt[31:0] and bubble_cnt[31:0], reset to 0 and wrapping.
  - fetch_cnt increments on each pop.
  - bubble_cnt increments each cycle with !if_valid && !stall.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Release reset, mem latency 1, ready=1 → imem_addr 0,4,8,...; if_valid first high cycle 2; pc=0, PCPlus4=4, instruction=mem[0].
- stall=1 for 5 cycles while streaming → head frozen, imem_req_valid drops once count+inflight=4, no loss or duplication after release.
- Two requests in flight, redirect to 0x100 → both late responses dropped; next if_valid shows pc=0x100, instruction=mem[0x100].
- redirect in the same cycle as rsp_valid and stall=1 → returning response dropped, FIFO empty next cycle, fetch at redirect_target.
- imem_req_ready low 3 cycles → imem_addr stable at 0x0C, fetch_pc unchanged, outputs show NOP_INSTR with if_valid=0 once drained.
- Assert rst with 3 entries buffered → immediately if_valid=0, imem_req_valid=0; after release imem_addr=RESET_PC.
